matmul_mmio_sequencer: RTL and testbench
========================================

Name: matmul_mmio_sequencer

Overview:
- MMIO initiator that drives the matmul accelerator's register window on behalf of a job source. This is the master side of the accelerator's MMIO slave port.
- Per job, it programs the config registers, checks queue space, issues start, polls for completion, and reads back the valid M×N result words as a valid/ready stream.
- Sits between a job source (core-side command queue or test controller) and the accelerator's mmio_* port.

Parameters:
- BASE_ADDR, 32'h8000_0000, accelerator MMIO base; register offsets are added to it.
- POLL_LIMIT, 1024, maximum status reads per wait phase (queue-full wait, done wait) before a timeout error.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- job_valid  input  1  job descriptor valid
- job_ready  output  1  high in IDLE only
- job_w_addr, job_x_addr  input  32 each  B/A packed vector bases
- job_m, job_n  input  32 each  valid rows/cols, legal range 1..4
- job_k  input  32  K element count
- job_x_stride, job_k_row_len  input  32 each  A row-jump bytes / blocks per row
- mmio_addr  output  32  register address
- mmio_wdata  output  32  write data
- mmio_we  output  4  byte enables; 4'hF on a write, else 0
- mmio_re  output  1  read strobe, one-cycle pulse
- mmio_rdata  input  32  read data, valid the cycle after mmio_re
- res_valid  output  1  result word valid
- res_ready  input  1  consumer accept
- res_data  output  32  signed dot-product result
- res_idx  output  4  4*i+j
- res_last  output  1  final result word of the job
- job_error  output  1  sticky; cleared when the next job is accepted
- busy  output  1  state != IDLE

Behaviour:
- Reset: state IDLE; mmio_addr, mmio_wdata, mmio_we, mmio_re, res_valid, res_data, res_idx, res_last, job_error, busy all 0.
- job_ready = (state == IDLE), so it is 1 in the first cycle after reset.
- All MMIO and result outputs are registered.
- Job accept (job_valid && job_ready):
  - Latch all descriptor fields and clear job_error.
  - If job_m or job_n is 0 or greater than 4: set job_error, stay IDLE, issue no MMIO traffic.
- WR_CFG: seven back-to-back write cycles, one per cycle, starting the cycle after accept. Offsets and data in order:
  - 0x04 w_addr, 0x08 x_addr, 0x0C m, 0x10 n, 0x14 k, 0x58 x_stride, 0x5C k_row_len.
- CHK_RD / CHK_WAIT:
  - Read offset 0x00 (mmio_re pulse), then sample mmio_rdata on the next cycle.
  - If bit[2] (full) is set, re-issue the read on the following cycle.
  - Otherwise go to START.
- START: one write to offset 0x00 with wdata = 32'h1. Never issued while the last sampled full bit = 1.
- POLL_RD / POLL_WAIT:
  - First poll read is issued the cycle after START.
  - Exit when sampled bit[1] (done) = 1 and bit[0] (busy) = 0.
  - Otherwise re-issue.
- Timeout:
  - A counter counts status reads within each wait phase and resets on phase entry.
  - At POLL_LIMIT reads without the exit condition: set job_error, go to IDLE, emit no results.
  - If the done poll times out, the accelerator may still hold the queued command; the job source owns recovery.
- RES_RD / RES_WAIT / RES_OUT: for i in 0..m-1, j in 0..n-1 (row-major):
  - Read address BASE_ADDR + 0x18 + 16*i + 4*j.
  - On the cycle after the read, capture mmio_rdata into res_data, set res_idx = 4*i + j, and assert res_valid.
  - res_last = 1 on the (m-1, n-1) word.
  - Hold res_data/res_idx/res_last stable until res_ready.
  - The next mmio_re is issued the cycle after the handshake.
  - After the last handshake, return to IDLE.
- Outside a read, mmio_re = 0; outside a write, mmio_we = 0.
- mmio_addr and mmio_wdata are don't-care when neither strobe is active; they hold their last value.
- K = 0 is legal and passed through (the accelerator returns zeros).
- Reset in any state returns to IDLE in the next cycle with all outputs at reset values. Any in-flight read data is discarded.

Test Plan:
- Job w=0x1000, x=0x2000, m=2, n=2, k=4, stride=16, row_len=1, accelerator done after 20 cycles:
  - Required: writes 0x80000004..0x8000005C in the listed order, then one status read, then start write wdata=1.
  - Required: results idx 0,1,4,5 from addresses 0x80000018, 0x8000001C, 0x80000028, 0x8000002C; res_last only on idx 5.
- job_m=0 and, separately, job_n=5 -> job_error=1 the cycle after accept; mmio_we and mmio_re stay 0; job_ready stays 1.
- Status model returns full=1 for 3 reads, then 0 -> exactly 4 status reads before start; no start write while full.
- POLL_LIMIT=8 and the status model never reports done -> exactly 8 poll reads, then job_error=1, IDLE, res_valid never asserted.
- res_ready held low 5 cycles on the 2nd result -> res_data and res_idx stable throughout, no mmio_re during the stall, 3rd read issued the cycle after accept.
- Reset asserted during POLL_WAIT -> next cycle all outputs 0 and job_ready=1; a following job runs normally.

Source files
------------

// File: rtl/matmul_mmio_sequencer.sv
// matmul_mmio_sequencer
// ---------------------
// MMIO initiator for the matmul accelerator. For each job descriptor it
// programs the config registers, waits for queue space, writes start, polls
// for completion and streams back the valid M x N result words.
//
// Handshakes:
//   job_*  : a descriptor is taken on a cycle where job_valid && job_ready;
//            job_ready is high only while the sequencer is idle.
//   res_*  : a result word transfers on a cycle where res_valid && res_ready;
//            res_data/res_idx/res_last hold stable while res_valid && !res_ready.
//   mmio_* : mmio_re is a one-cycle read pulse, mmio_rdata is sampled on the
//            following cycle; mmio_we = 4'hF marks a one-cycle write.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   job_valid / job_ready      descriptor handshake
//   job_w_addr .. job_k_row_len descriptor fields (m, n legal range 1..4)
//   mmio_addr/wdata/we/re      register-window request (all registered)
//   mmio_rdata                 read data, valid the cycle after mmio_re
//   res_valid/ready/data/idx/last  result stream, idx = 4*i + j
//   job_error                  sticky error, cleared on the next accept
//   busy                       sequencer not idle
//   dbg_state                  current FSM state
module matmul_mmio_sequencer #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          POLL_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [31:0] job_w_addr,
  input  logic [31:0] job_x_addr,
  input  logic [31:0] job_m,
  input  logic [31:0] job_n,
  input  logic [31:0] job_k,
  input  logic [31:0] job_x_stride,
  input  logic [31:0] job_k_row_len,
  output logic [31:0] mmio_addr,
  output logic [31:0] mmio_wdata,
  output logic [3:0]  mmio_we,
  output logic        mmio_re,
  input  logic [31:0] mmio_rdata,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [3:0]  res_idx,
  output logic        res_last,
  output logic        job_error,
  output logic        busy,
  output logic [3:0]  dbg_state
);

  localparam int CW = $clog2(POLL_LIMIT + 1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_WR_CFG    = 4'd1,
    S_CHK_RD    = 4'd2,
    S_CHK_WAIT  = 4'd3,
    S_START     = 4'd4,
    S_POLL_RD   = 4'd5,
    S_POLL_WAIT = 4'd6,
    S_RES_RD    = 4'd7,
    S_RES_WAIT  = 4'd8,
    S_RES_OUT   = 4'd9
  } state_t;

  state_t        r_state;
  logic [2:0]    r_cfg_idx;
  logic [CW-1:0] r_poll_cnt;
  logic [1:0]    r_i;
  logic [1:0]    r_j;

  logic [31:0] r_w_addr, r_x_addr, r_m, r_n, r_k, r_x_stride, r_k_row_len;

  logic [31:0] r_mmio_addr;
  logic [31:0] r_mmio_wdata;
  logic [3:0]  r_mmio_we;
  logic        r_mmio_re;
  logic        r_res_valid;
  logic [31:0] r_res_data;
  logic [3:0]  r_res_idx;
  logic        r_res_last;
  logic        r_job_error;

  logic        w_accept;
  logic        w_job_ok;
  logic [2:0]  w_cfg_nxt;
  logic [7:0]  w_cfg_off;
  logic [31:0] w_cfg_data;
  logic        w_full;
  logic        w_done_exit;
  logic        w_poll_max;
  logic [1:0]  w_m_m1;
  logic [1:0]  w_n_m1;
  logic        w_last_col;
  logic        w_last_word;
  logic [1:0]  w_ni;
  logic [1:0]  w_nj;

  assign w_accept    = job_valid && (r_state == S_IDLE);
  assign w_job_ok    = (job_m != 32'd0) && (job_m <= 32'd4) &&
                       (job_n != 32'd0) && (job_n <= 32'd4);
  assign w_cfg_nxt   = r_cfg_idx + 3'd1;
  assign w_full      = mmio_rdata[2];
  assign w_done_exit = mmio_rdata[1] && !mmio_rdata[0];
  assign w_poll_max  = (r_poll_cnt == CW'(POLL_LIMIT));

  // m and n are 1..4 here, so the 2-bit wrap of m-1 / n-1 is exact (4 -> 3).
  assign w_m_m1      = r_m[1:0] - 2'd1;
  assign w_n_m1      = r_n[1:0] - 2'd1;
  assign w_last_col  = (r_j == w_n_m1);
  assign w_last_word = w_last_col && (r_i == w_m_m1);
  assign w_ni        = w_last_col ? r_i + 2'd1 : r_i;
  assign w_nj        = w_last_col ? 2'd0 : r_j + 2'd1;

  // Config write table; entry 0 (w_addr) is issued straight from the
  // descriptor inputs on the accept edge, so only 1..6 come from here.
  always_comb begin
    w_cfg_off  = 8'h04;
    w_cfg_data = r_w_addr;
    case (w_cfg_nxt)
      3'd1: begin w_cfg_off = 8'h08; w_cfg_data = r_x_addr;    end
      3'd2: begin w_cfg_off = 8'h0C; w_cfg_data = r_m;         end
      3'd3: begin w_cfg_off = 8'h10; w_cfg_data = r_n;         end
      3'd4: begin w_cfg_off = 8'h14; w_cfg_data = r_k;         end
      3'd5: begin w_cfg_off = 8'h58; w_cfg_data = r_x_stride;  end
      3'd6: begin w_cfg_off = 8'h5C; w_cfg_data = r_k_row_len; end
      default: begin w_cfg_off = 8'h04; w_cfg_data = r_w_addr; end
    endcase
  end

  function automatic logic [31:0] f_res_addr(input logic [1:0] i, input logic [1:0] j);
    return BASE_ADDR + 32'h18 + {26'd0, i, j, 2'b00};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cfg_idx    <= 3'd0;
      r_poll_cnt   <= '0;
      r_i          <= 2'd0;
      r_j          <= 2'd0;
      r_w_addr     <= 32'd0;
      r_x_addr     <= 32'd0;
      r_m          <= 32'd0;
      r_n          <= 32'd0;
      r_k          <= 32'd0;
      r_x_stride   <= 32'd0;
      r_k_row_len  <= 32'd0;
      r_mmio_addr  <= 32'd0;
      r_mmio_wdata <= 32'd0;
      r_mmio_we    <= 4'd0;
      r_mmio_re    <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_data   <= 32'd0;
      r_res_idx    <= 4'd0;
      r_res_last   <= 1'b0;
      r_job_error  <= 1'b0;
    end else begin
      // Strobes are single-cycle unless a state re-arms them below.
      r_mmio_we <= 4'd0;
      r_mmio_re <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_w_addr    <= job_w_addr;
            r_x_addr    <= job_x_addr;
            r_m         <= job_m;
            r_n         <= job_n;
            r_k         <= job_k;
            r_x_stride  <= job_x_stride;
            r_k_row_len <= job_k_row_len;
            r_job_error <= !w_job_ok;
            if (w_job_ok) begin
              r_mmio_addr  <= BASE_ADDR + 32'h04;
              r_mmio_wdata <= job_w_addr;
              r_mmio_we    <= 4'hF;
              r_cfg_idx    <= 3'd0;
              r_state      <= S_WR_CFG;
            end
          end
        end
        S_WR_CFG: begin
          if (r_cfg_idx == 3'd6) begin
            r_mmio_addr <= BASE_ADDR;
            r_mmio_re   <= 1'b1;
            r_poll_cnt  <= CW'(1);
            r_state     <= S_CHK_RD;
          end else begin
            r_mmio_addr  <= BASE_ADDR + {24'd0, w_cfg_off};
            r_mmio_wdata <= w_cfg_data;
            r_mmio_we    <= 4'hF;
            r_cfg_idx    <= w_cfg_nxt;
          end
        end
        S_CHK_RD: r_state <= S_CHK_WAIT;
        S_CHK_WAIT: begin
          if (!w_full) begin
            r_mmio_addr  <= BASE_ADDR;
            r_mmio_wdata <= 32'h1;
            r_mmio_we    <= 4'hF;
            r_state      <= S_START;
          end else if (w_poll_max) begin
            r_job_error <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_mmio_addr <= BASE_ADDR;
            r_mmio_re   <= 1'b1;
            r_poll_cnt  <= r_poll_cnt + CW'(1);
            r_state     <= S_CHK_RD;
          end
        end
        S_START: begin
          r_mmio_addr <= BASE_ADDR;
          r_mmio_re   <= 1'b1;
          r_poll_cnt  <= CW'(1);
          r_state     <= S_POLL_RD;
        end
        S_POLL_RD: r_state <= S_POLL_WAIT;
        S_POLL_WAIT: begin
          if (w_done_exit) begin
            r_i         <= 2'd0;
            r_j         <= 2'd0;
            r_mmio_addr <= f_res_addr(2'd0, 2'd0);
            r_mmio_re   <= 1'b1;
            r_state     <= S_RES_RD;
          end else if (w_poll_max) begin
            // The accelerator may still own the command; recovery is left
            // to the job source.
            r_job_error <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_mmio_addr <= BASE_ADDR;
            r_mmio_re   <= 1'b1;
            r_poll_cnt  <= r_poll_cnt + CW'(1);
            r_state     <= S_POLL_RD;
          end
        end
        S_RES_RD: r_state <= S_RES_WAIT;
        S_RES_WAIT: begin
          r_res_valid <= 1'b1;
          r_res_data  <= mmio_rdata;
          r_res_idx   <= {r_i, r_j};
          r_res_last  <= w_last_word;
          r_state     <= S_RES_OUT;
        end
        S_RES_OUT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            if (r_res_last) begin
              r_state <= S_IDLE;
            end else begin
              r_i         <= w_ni;
              r_j         <= w_nj;
              r_mmio_addr <= f_res_addr(w_ni, w_nj);
              r_mmio_re   <= 1'b1;
              r_state     <= S_RES_RD;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign job_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign dbg_state  = r_state;
  assign mmio_addr  = r_mmio_addr;
  assign mmio_wdata = r_mmio_wdata;
  assign mmio_we    = r_mmio_we;
  assign mmio_re    = r_mmio_re;
  assign res_valid  = r_res_valid;
  assign res_data   = r_res_data;
  assign res_idx    = r_res_idx;
  assign res_last   = r_res_last;
  assign job_error  = r_job_error;

endmodule

// File: tb/tb_matmul_mmio_sequencer.sv
// Bench for matmul_mmio_sequencer: a behavioural accelerator register window
// answers MMIO traffic, expected writes / result reads / result words are
// queued at job issue and a monitor pops and compares them as they appear.
// A second instance with POLL_LIMIT=8 faces an accelerator that never
// finishes, to exercise the done-poll timeout.
module tb_matmul_mmio_sequencer;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        job_valid = 1'b0, job_valid_t = 1'b0;
  logic [31:0] job_w_addr = '0, job_x_addr = '0, job_m = '0, job_n = '0;
  logic [31:0] job_k = '0, job_x_stride = '0, job_k_row_len = '0;
  logic        job_ready, job_ready_t;
  logic [31:0] mmio_addr, mmio_wdata, mmio_addr_t, mmio_wdata_t;
  logic [3:0]  mmio_we, mmio_we_t;
  logic        mmio_re, mmio_re_t;
  logic [31:0] mmio_rdata = '0, mmio_rdata_t = '0;
  logic        res_valid, res_valid_t, res_last, res_last_t;
  logic        res_ready = 1'b1, res_ready_t = 1'b1;
  logic [31:0] res_data, res_data_t;
  logic [3:0]  res_idx, res_idx_t, dbg_state, dbg_state_t;
  logic        job_error, job_error_t, busy, busy_t;

  matmul_mmio_sequencer #(.BASE_ADDR(BASE), .POLL_LIMIT(1024)) dut (
    .clk(clk), .reset(reset), .job_valid(job_valid), .job_ready(job_ready),
    .job_w_addr(job_w_addr), .job_x_addr(job_x_addr), .job_m(job_m), .job_n(job_n),
    .job_k(job_k), .job_x_stride(job_x_stride), .job_k_row_len(job_k_row_len),
    .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata), .mmio_we(mmio_we), .mmio_re(mmio_re),
    .mmio_rdata(mmio_rdata), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_idx(res_idx), .res_last(res_last),
    .job_error(job_error), .busy(busy), .dbg_state(dbg_state));

  matmul_mmio_sequencer #(.BASE_ADDR(BASE), .POLL_LIMIT(8)) dut_t (
    .clk(clk), .reset(reset), .job_valid(job_valid_t), .job_ready(job_ready_t),
    .job_w_addr(job_w_addr), .job_x_addr(job_x_addr), .job_m(job_m), .job_n(job_n),
    .job_k(job_k), .job_x_stride(job_x_stride), .job_k_row_len(job_k_row_len),
    .mmio_addr(mmio_addr_t), .mmio_wdata(mmio_wdata_t), .mmio_we(mmio_we_t), .mmio_re(mmio_re_t),
    .mmio_rdata(mmio_rdata_t), .res_valid(res_valid_t), .res_ready(res_ready_t),
    .res_data(res_data_t), .res_idx(res_idx_t), .res_last(res_last_t),
    .job_error(job_error_t), .busy(busy_t), .dbg_state(dbg_state_t));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard queues.
  logic [63:0] exp_wr_q[$];   // {addr, data}
  logic [31:0] exp_rd_q[$];   // result read addresses
  logic [36:0] exp_res_q[$];  // {last, idx, data}

  // Accelerator model state.
  int          cyc = 0;
  bit          active = 0, started = 0, last_full = 0, last_done = 0;
  int          full_left = 0, done_at = 0, done_delay = 0, chk_reads = 0, poll_reads = 0;
  logic [31:0] acc_res[16];
  logic [31:0] pend_rd = '0, t_pend = '0;
  bit          pend_v = 0, t_pend_v = 0;
  bit          stall_job = 0, rand_ready = 0;
  int          stall_cnt = 0, word_num = 0;
  bit          held = 0, exp_re_next = 0;
  logic [31:0] h_data;
  logic [3:0]  h_idx;
  logic        h_last;
  bit          t_started = 0;
  int          t_chk = 0, t_poll = 0, t_res_seen = 0;

  // Monitor / responder, sampling 1 time unit after each rising edge.
  always @(posedge clk) begin
    logic [63:0] e;
    logic [31:0] ea, off;
    logic [36:0] er;
    #1;
    cyc++;
    // Read data is presented only in the cycle after a read; junk otherwise.
    mmio_rdata   = pend_v ? pend_rd : $urandom;
    mmio_rdata_t = t_pend_v ? t_pend : $urandom;
    pend_v = 0;
    t_pend_v = 0;
    if (reset) begin
      held = 0;
      exp_re_next = 0;
      res_ready = 1'b1;
    end else begin
      if (exp_re_next) begin
        chk("re_cycle_after_handshake", mmio_re, 1);
        exp_re_next = 0;
      end
      if (held) begin
        chk("stall_valid_held", res_valid, 1);
        chk("stall_data_stable", res_data, h_data);
        chk("stall_idx_stable", res_idx, h_idx);
        chk("stall_last_stable", res_last, h_last);
        held = 0;
      end
      if (mmio_we != 4'd0) begin
        chk("we_mask", mmio_we, 4'hF);
        chk("write_expected", exp_wr_q.size() > 0, 1);
        if (exp_wr_q.size() > 0) begin
          e = exp_wr_q.pop_front();
          chk("wr_addr", mmio_addr, e[63:32]);
          chk("wr_data", mmio_wdata, e[31:0]);
        end
        if (mmio_addr == BASE) begin
          chk("start_only_when_not_full", last_full, 0);
          started = 1;
          last_done = 0;
          done_at = cyc + done_delay;
        end
      end
      if (mmio_re) begin
        chk("read_expected", active, 1);
        if (mmio_addr == BASE) begin
          if (!started) begin
            if (chk_reads > 0) chk("status_reread_only_if_full", last_full, 1);
            chk_reads++;
            last_full = (full_left > 0);
            if (full_left > 0) full_left--;
            pend_rd = {29'd0, last_full, 2'b00};
          end else begin
            if (poll_reads > 0) chk("no_poll_after_done", last_done, 0);
            poll_reads++;
            last_done = (cyc >= done_at);
            pend_rd = {30'd0, last_done, !last_done};
          end
        end else begin
          chk("result_read_expected", exp_rd_q.size() > 0, 1);
          chk("results_only_after_done", last_done, 1);
          if (exp_rd_q.size() > 0) begin
            ea = exp_rd_q.pop_front();
            chk("rd_addr", mmio_addr, ea);
          end
          off = mmio_addr - BASE - 32'h18;
          pend_rd = (off < 32'd64) ? acc_res[off[5:2]] : $urandom;
        end
        pend_v = 1;
      end
      // Consumer: decide res_ready for this cycle, then score a transfer.
      if (res_valid) begin
        chk("no_re_while_result_pending", mmio_re, 0);
        if (stall_job && word_num == 1 && stall_cnt < 5) begin
          res_ready = 1'b0;
          stall_cnt++;
        end else begin
          res_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
        if (res_ready) begin
          chk("result_expected", exp_res_q.size() > 0, 1);
          if (exp_res_q.size() > 0) begin
            er = exp_res_q.pop_front();
            chk("res_data", res_data, er[31:0]);
            chk("res_idx", res_idx, er[35:32]);
            chk("res_last", res_last, er[36]);
          end
          word_num++;
          if (!res_last) exp_re_next = 1;
        end else begin
          held = 1;
          h_data = res_data;
          h_idx = res_idx;
          h_last = res_last;
        end
      end else begin
        res_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      // Timeout instance: accelerator reports busy forever.
      if (mmio_we_t != 4'd0 && mmio_addr_t == BASE) t_started = 1;
      if (mmio_re_t) begin
        if (t_started) t_poll++;
        else t_chk++;
        t_pend = 32'h1;
        t_pend_v = 1;
      end
      if (res_valid_t) t_res_seen++;
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_mmio_addr"}, mmio_addr, 0);
    chk({tag, "_mmio_wdata"}, mmio_wdata, 0);
    chk({tag, "_mmio_we"}, mmio_we, 0);
    chk({tag, "_mmio_re"}, mmio_re, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_data"}, res_data, 0);
    chk({tag, "_res_idx"}, res_idx, 0);
    chk({tag, "_res_last"}, res_last, 0);
    chk({tag, "_job_error"}, job_error, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_job_ready"}, job_ready, 1);
  endtask

  task automatic start_job(input logic [31:0] w, x, m, n, k, st, rl,
                           input int nfull, input int ddel, input bit stall, input bit rr);
    exp_wr_q.delete();
    exp_rd_q.delete();
    exp_res_q.delete();
    active = 1; started = 0; last_full = 0; last_done = 0;
    full_left = nfull; done_delay = ddel; chk_reads = 0; poll_reads = 0;
    stall_job = stall; stall_cnt = 0; word_num = 0; rand_ready = rr;
    for (int i = 0; i < 16; i++) acc_res[i] = (k == 0) ? 32'd0 : $urandom;
    exp_wr_q.push_back({BASE + 32'h04, w});
    exp_wr_q.push_back({BASE + 32'h08, x});
    exp_wr_q.push_back({BASE + 32'h0C, m});
    exp_wr_q.push_back({BASE + 32'h10, n});
    exp_wr_q.push_back({BASE + 32'h14, k});
    exp_wr_q.push_back({BASE + 32'h58, st});
    exp_wr_q.push_back({BASE + 32'h5C, rl});
    exp_wr_q.push_back({BASE, 32'h1});
    for (int i = 0; i < int'(m); i++)
      for (int j = 0; j < int'(n); j++) begin
        exp_rd_q.push_back(BASE + 32'h18 + 32'(16 * i + 4 * j));
        exp_res_q.push_back({(i == int'(m) - 1) && (j == int'(n) - 1), 4'(4 * i + j),
                             acc_res[4 * i + j]});
      end
    @(negedge clk);
    job_w_addr = w; job_x_addr = x; job_m = m; job_n = n;
    job_k = k; job_x_stride = st; job_k_row_len = rl;
    chk("job_ready_before_accept", job_ready, 1);
    job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    chk("error_cleared_on_accept", job_error, 0);
    chk("busy_after_accept", busy, 1);
    chk("job_ready_low_when_busy", job_ready, 0);
    for (int c = 0; c < 7; c++) begin
      chk("cfg_writes_back_to_back", mmio_we, 4'hF);
      @(negedge clk);
    end
    chk("status_read_after_cfg", mmio_re, 1);
    chk("status_read_addr", mmio_addr, BASE);
  endtask

  task automatic finish_job(input int nfull);
    for (int t = 0; t < 3000 && busy; t++) @(negedge clk);
    chk("job_completes_in_time", busy, 0);
    chk("writes_drained", exp_wr_q.size(), 0);
    chk("result_reads_drained", exp_rd_q.size(), 0);
    chk("results_drained", exp_res_q.size(), 0);
    chk("status_reads_before_start", chk_reads, nfull + 1);
    chk("no_error_on_good_job", job_error, 0);
    active = 0;
    @(negedge clk);
  endtask

  task automatic run_job(input logic [31:0] w, x, m, n, k, st, rl,
                         input int nfull, input int ddel, input bit stall, input bit rr);
    start_job(w, x, m, n, k, st, rl, nfull, ddel, stall, rr);
    finish_job(nfull);
  endtask

  task automatic err_job(input logic [31:0] m, input logic [31:0] n);
    @(negedge clk);
    job_m = m; job_n = n; job_k = 32'd4;
    job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    chk("bad_dims_error", job_error, 1);
    chk("bad_dims_job_ready", job_ready, 1);
    chk("bad_dims_not_busy", busy, 0);
    chk("bad_dims_no_we", mmio_we, 0);
    chk("bad_dims_no_re", mmio_re, 0);
    repeat (4) @(negedge clk);
    chk("bad_dims_still_idle", job_ready, 1);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    chk("reset_job_ready_t", job_ready_t, 1);
    reset = 1'b0;
    @(negedge clk);
    chk("job_ready_after_reset", job_ready, 1);

    // Reference job from the plan.
    run_job(32'h1000, 32'h2000, 2, 2, 4, 16, 1, 0, 20, 0, 0);

    // Illegal dimensions.
    err_job(0, 2);
    err_job(2, 5);
    err_job(1, 0);

    // Queue full for three status reads, then space.
    run_job(32'h3000, 32'h4000, 2, 3, 8, 32, 2, 3, 6, 0, 0);

    // Second result stalled for five cycles.
    run_job(32'h5000, 32'h6000, 3, 2, 5, 20, 1, 0, 4, 1, 0);

    // Boundaries: K=0 with 1x1, and full 4x4 with a ragged consumer.
    run_job(32'h7000, 32'h8000, 1, 1, 0, 0, 0, 1, 0, 0, 0);
    run_job(32'h9000, 32'hA000, 4, 4, 16, 64, 4, 0, 11, 0, 1);

    // Randomized jobs.
    for (int r = 0; r < 8; r++)
      run_job($urandom, $urandom, $urandom_range(1, 4), $urandom_range(1, 4),
              $urandom_range(0, 64), $urandom, $urandom_range(1, 8),
              $urandom_range(0, 3), $urandom_range(0, 30), $urandom_range(0, 1), 1);

    // Done-poll timeout on the POLL_LIMIT=8 instance.
    t_started = 0; t_chk = 0; t_poll = 0; t_res_seen = 0;
    @(negedge clk);
    job_m = 2; job_n = 2; job_k = 4;
    job_valid_t = 1'b1;
    @(negedge clk);
    job_valid_t = 1'b0;
    for (int t = 0; t < 300 && busy_t; t++) @(negedge clk);
    chk("timeout_returns_idle", busy_t, 0);
    chk("timeout_job_ready", job_ready_t, 1);
    chk("timeout_error", job_error_t, 1);
    chk("timeout_poll_reads", t_poll, 8);
    chk("timeout_status_reads", t_chk, 1);
    chk("timeout_no_results", t_res_seen, 0);

    // Reset while waiting on a poll read, then a normal job.
    start_job(32'hB000, 32'hC000, 2, 2, 4, 16, 1, 0, 200, 0, 0);
    for (int t = 0; t < 200 && !(started && mmio_re); t++) @(negedge clk);
    chk("reached_poll_read", started && mmio_re, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("midjob_reset");
    reset = 1'b0;
    active = 0;
    exp_wr_q.delete();
    exp_rd_q.delete();
    exp_res_q.delete();
    repeat (2) @(negedge clk);
    run_job(32'hD000, 32'hE000, 2, 3, 7, 24, 1, 1, 9, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    n_err++;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
